wb_load_unit: RTL and testbench
===============================

# wb_load_unit

Parametrised writeback stage that replaces the purely combinational writeback path. It accepts one instruction per cycle from the MEM stage over a valid/ready handshake. For loads it waits a variable number of cycles for the RAM read response, then aligns and sign/zero-extends the returned lane. It presents a registered regfile/HILO write, plus debug PC, one cycle later, with misalignment detection and pipeline flush support.

## Interface
- DATA_WIDTH, 32, datapath and RAM read width; 32 or 64
- ADDR_WIDTH, 32, address/PC width
- REG_ADDR_WIDTH, 5, regfile address width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  unit can accept this cycle
- flush  in  1  kill in-flight instruction (synchronous)
- mem_read_flag  in  1  instruction is a load
- mem_write_flag  in  1  instruction is a store
- mem_sign_flag  in  1  sign-extend load (else zero-extend)
- mem_size  in  2  0 byte, 1 half, 2 word, 3 double
- result_in  in  DATA_WIDTH  ALU result, or effective address for load/store
- reg_write_en_in  in  1  regfile write requested
- reg_write_addr_in  in  REG_ADDR_WIDTH  destination register
- current_pc_addr_in  in  ADDR_WIDTH  instruction PC
- hi_write_data_in, lo_write_data_in  in  DATA_WIDTH  HILO data
- hilo_write_en_in  in  1  HILO write requested
- ram_rvalid  in  1  RAM read response valid
- ram_read_data  in  DATA_WIDTH  RAM read data, full aligned word
- wb_valid  out  1  registered writeback beat
- result_out  out  DATA_WIDTH  data to regfile
- reg_write_en_out  out  1  regfile write strobe
- reg_write_addr_out  out  REG_ADDR_WIDTH  regfile address
- hi_write_data_out, lo_write_data_out  out  DATA_WIDTH  HILO data
- hilo_write_en_out  out  1  HILO write strobe
- load_misaligned  out  1  one-cycle exception pulse
- debug_reg_write_en  out  1  equals reg_write_en_out
- debug_pc_addr_out  out  ADDR_WIDTH  PC of the current writeback beat

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - WAIT_RD: in_ready=0; holds captured load fields.
  - DRAIN: in_ready=0; flushed load awaiting response.
- Accept = in_valid & in_ready & ~flush.
- Accept of a non-load in IDLE: next cycle wb_valid=1 and fields registered.
  - result_out = 0 for stores, result_in otherwise.
  - reg_write_en_out = reg_write_en_in & ~mem_write_flag.
  - HILO outputs are passed through.
- Accept of a load in IDLE:
  - Lane offset = result_in[log2(DATA_WIDTH/8)-1:0].
  - Misaligned if offset is not a multiple of (1<<mem_size).
  - mem_size=3 with DATA_WIDTH=32 is illegal and treated as misaligned.
- Misaligned or illegal load: no RAM wait; next cycle wb_valid=1, load_misaligned=1, reg_write_en_out=0, result_out=0, hilo_write_en_out=0; stay IDLE.
- Aligned load: capture fields and go to WAIT_RD.
- WAIT_RD with ram_rvalid=1:
  - Select bytes [offset*8 +: 8<<mem_size].
  - Extend to DATA_WIDTH, using sign extension when mem_sign_flag=1.
  - Next cycle: wb_valid=1, result_out = extended value, reg_write_en_out = captured enable; return to IDLE.
- ram_rvalid is ignored in IDLE; it must not arrive in the cycle a load is accepted.
- flush in IDLE: input ignored, no beat produced.
- flush in WAIT_RD: go to DRAIN.
  - If ram_rvalid is high in the same cycle, discard the response and go to IDLE.
- DRAIN: discard the response on ram_rvalid, then go to IDLE; no beat is produced.
- flush does not cancel a beat already on the outputs.
- In every cycle with wb_valid=0, the strobes reg_write_en_out, hilo_write_en_out and load_misaligned are 0.

## Timing
- Reset (rst=0, async): state IDLE. All outputs are 0 except in_ready=1.
- Non-load latency: 1 cycle from accept to wb_valid. Throughput is 1 per cycle.
- Load latency: wb_valid is asserted the cycle after ram_rvalid. Minimum 2 cycles from accept.
- in_ready is combinational from state only (IDLE), with no dependency on in_valid.
- A non-load may be accepted in the cycle immediately after a load's wb_valid.
- All outputs are registered; none are combinational from inputs.
- Reset asserted mid-load: immediate return to IDLE; any later ram_rvalid is ignored.

## Test plan
- ALU op, result_in=0x1234_5678, reg_write_en_in=1, addr 7 -> one cycle later: wb_valid=1, result_out=0x12345678, reg_write_en_out=1, reg_write_addr_out=7.
- LB sign, addr offset 3, ram_rvalid after 4 cycles with data 0x80FF_0000 -> result_out=0xFFFF_FF80. LBU, same data -> 0x0000_0080.
- LH at offset 1 -> load_misaligned=1, reg_write_en_out=0, no RAM wait. Back-to-back ALU op accepted the next cycle.
- DATA_WIDTH=64, LD at offset 0, data 0x0123_4567_89AB_CDEF -> result_out equals data. LW sign at offset 4 on the same data -> 0x0000_0000_0123_4567.
- Load accepted, flush while in WAIT_RD, ram_rvalid 2 cycles later -> no wb_valid. in_ready returns to 1 the cycle after ram_rvalid.
- rst pulse while in WAIT_RD -> outputs 0, in_ready=1. A subsequent stray ram_rvalid produces no beat.

Source files
------------

// File: rtl/wb_load_unit.sv
// Writeback stage with a variable-latency load return path.
// Loads wait for the RAM read response, then the selected lane is aligned and extended.
module wb_load_unit #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      flush,
   input  logic                      mem_read_flag,
   input  logic                      mem_write_flag,
   input  logic                      mem_sign_flag,
   input  logic [1:0]                mem_size,
   input  logic [DATA_WIDTH-1:0]     result_in,
   input  logic                      reg_write_en_in,
   input  logic [REG_ADDR_WIDTH-1:0] reg_write_addr_in,
   input  logic [ADDR_WIDTH-1:0]     current_pc_addr_in,
   input  logic [DATA_WIDTH-1:0]     hi_write_data_in,
   input  logic [DATA_WIDTH-1:0]     lo_write_data_in,
   input  logic                      hilo_write_en_in,
   input  logic                      ram_rvalid,
   input  logic [DATA_WIDTH-1:0]     ram_read_data,
   output logic                      wb_valid,
   output logic [DATA_WIDTH-1:0]     result_out,
   output logic                      reg_write_en_out,
   output logic [REG_ADDR_WIDTH-1:0] reg_write_addr_out,
   output logic [DATA_WIDTH-1:0]     hi_write_data_out,
   output logic [DATA_WIDTH-1:0]     lo_write_data_out,
   output logic                      hilo_write_en_out,
   output logic                      load_misaligned,
   output logic                      debug_reg_write_en,
   output logic [ADDR_WIDTH-1:0]     debug_pc_addr_out
);

   localparam int OFF_W = $clog2(DATA_WIDTH / 8);

   typedef enum logic [1:0] {IDLE, WAIT_RD, DRAIN} state_t;
   state_t state;

   // fields of the load parked in WAIT_RD
   logic [OFF_W-1:0]          ld_off;
   logic [1:0]                ld_size;
   logic                      ld_sign;
   logic                      ld_rwe;
   logic [REG_ADDR_WIDTH-1:0] ld_raddr;
   logic [ADDR_WIDTH-1:0]     ld_pc;
   logic [DATA_WIDTH-1:0]     ld_hi;
   logic [DATA_WIDTH-1:0]     ld_lo;
   logic                      ld_hwe;

   logic                  accept;
   logic [OFF_W-1:0]      in_off;
   logic [OFF_W-1:0]      size_mask;
   logic                  misaligned;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] lane_mask;
   logic                  lane_msb;
   logic [DATA_WIDTH-1:0] ld_ext;

   assign in_ready           = (state == IDLE);
   assign accept             = in_valid & in_ready & ~flush;
   assign debug_reg_write_en = reg_write_en_out;
   assign in_off             = result_in[OFF_W-1:0];

   // a double on a 32-bit datapath is illegal and reported like a misalignment
   always_comb begin
      size_mask = '0;
      case (mem_size)
         2'd0:    size_mask = '0;
         2'd1:    size_mask = OFF_W'(1);
         2'd2:    size_mask = OFF_W'(3);
         default: size_mask = OFF_W'(7);
      endcase
      misaligned = (|(in_off & size_mask)) |
                   ((mem_size == 2'd3) && (DATA_WIDTH < 64));
   end

   always_comb begin
      shifted   = ram_read_data >> {ld_off, 3'b000};
      lane_mask = '1;
      lane_msb  = shifted[DATA_WIDTH-1];
      case (ld_size)
         2'd0: begin
            lane_mask = DATA_WIDTH'(8'hFF);
            lane_msb  = shifted[7];
         end
         2'd1: begin
            lane_mask = DATA_WIDTH'(16'hFFFF);
            lane_msb  = shifted[15];
         end
         2'd2: begin
            lane_mask = DATA_WIDTH'(32'hFFFF_FFFF);
            lane_msb  = shifted[31];
         end
         default: begin
            lane_mask = '1;
            lane_msb  = shifted[DATA_WIDTH-1];
         end
      endcase
      ld_ext = (shifted & lane_mask) | ((ld_sign & lane_msb) ? ~lane_mask : '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state              <= IDLE;
         wb_valid           <= 1'b0;
         result_out         <= '0;
         reg_write_en_out   <= 1'b0;
         reg_write_addr_out <= '0;
         hi_write_data_out  <= '0;
         lo_write_data_out  <= '0;
         hilo_write_en_out  <= 1'b0;
         load_misaligned    <= 1'b0;
         debug_pc_addr_out  <= '0;
         ld_off             <= '0;
         ld_size            <= '0;
         ld_sign            <= 1'b0;
         ld_rwe             <= 1'b0;
         ld_raddr           <= '0;
         ld_pc              <= '0;
         ld_hi              <= '0;
         ld_lo              <= '0;
         ld_hwe             <= 1'b0;
      end else begin
         // strobes only live for the single beat cycle; data fields hold
         wb_valid          <= 1'b0;
         reg_write_en_out  <= 1'b0;
         hilo_write_en_out <= 1'b0;
         load_misaligned   <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (!mem_read_flag) begin
                     wb_valid           <= 1'b1;
                     result_out         <= mem_write_flag ? '0 : result_in;
                     reg_write_en_out   <= reg_write_en_in & ~mem_write_flag;
                     reg_write_addr_out <= reg_write_addr_in;
                     hi_write_data_out  <= hi_write_data_in;
                     lo_write_data_out  <= lo_write_data_in;
                     hilo_write_en_out  <= hilo_write_en_in;
                     debug_pc_addr_out  <= current_pc_addr_in;
                  end else if (misaligned) begin
                     wb_valid           <= 1'b1;
                     load_misaligned    <= 1'b1;
                     result_out         <= '0;
                     reg_write_addr_out <= reg_write_addr_in;
                     hi_write_data_out  <= hi_write_data_in;
                     lo_write_data_out  <= lo_write_data_in;
                     debug_pc_addr_out  <= current_pc_addr_in;
                  end else begin
                     ld_off   <= in_off;
                     ld_size  <= mem_size;
                     ld_sign  <= mem_sign_flag;
                     ld_rwe   <= reg_write_en_in;
                     ld_raddr <= reg_write_addr_in;
                     ld_pc    <= current_pc_addr_in;
                     ld_hi    <= hi_write_data_in;
                     ld_lo    <= lo_write_data_in;
                     ld_hwe   <= hilo_write_en_in;
                     state    <= WAIT_RD;
                  end
               end
            end
            WAIT_RD: begin
               if (flush) begin
                  // a response arriving with the flush is simply dropped
                  state <= ram_rvalid ? IDLE : DRAIN;
               end else if (ram_rvalid) begin
                  wb_valid           <= 1'b1;
                  result_out         <= ld_ext;
                  reg_write_en_out   <= ld_rwe;
                  reg_write_addr_out <= ld_raddr;
                  hi_write_data_out  <= ld_hi;
                  lo_write_data_out  <= ld_lo;
                  hilo_write_en_out  <= ld_hwe;
                  debug_pc_addr_out  <= ld_pc;
                  state              <= IDLE;
               end
            end
            DRAIN: begin
               if (ram_rvalid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_load_unit.sv
// Directed bench for wb_load_unit: 32-bit vector table plus hand sequences,
// and a 64-bit instance for double and upper-lane loads.
module tb_wb_load_unit;

   logic        clk, rst;
   logic        in_valid, in_ready, flush;
   logic        mem_read_flag, mem_write_flag, mem_sign_flag;
   logic [1:0]  mem_size;
   logic [31:0] result_in, hi_in, lo_in;
   logic        rwe_in, hwe_in;
   logic [4:0]  raddr_in;
   logic [31:0] pc_in;
   logic        ram_rvalid;
   logic [31:0] ram_read_data;
   logic        wb_valid, rwe_out, hwe_out, mis, dbg_en;
   logic [31:0] result_out, hi_out, lo_out, dbg_pc;
   logic [4:0]  raddr_out;

   logic        w_in_valid, w_in_ready, w_read, w_sign;
   logic [1:0]  w_size;
   logic [63:0] w_result_in, w_rdata, w_result_out, w_hi_out, w_lo_out;
   logic        w_rvalid, w_wb_valid, w_rwe_out, w_hwe_out, w_mis, w_dbg_en;
   logic [4:0]  w_raddr_out;
   logic [31:0] w_dbg_pc;

   int n_cmp = 0;
   int n_bad = 0;

   wb_load_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
      .mem_sign_flag(mem_sign_flag), .mem_size(mem_size), .result_in(result_in),
      .reg_write_en_in(rwe_in), .reg_write_addr_in(raddr_in), .current_pc_addr_in(pc_in),
      .hi_write_data_in(hi_in), .lo_write_data_in(lo_in), .hilo_write_en_in(hwe_in),
      .ram_rvalid(ram_rvalid), .ram_read_data(ram_read_data), .wb_valid(wb_valid),
      .result_out(result_out), .reg_write_en_out(rwe_out), .reg_write_addr_out(raddr_out),
      .hi_write_data_out(hi_out), .lo_write_data_out(lo_out), .hilo_write_en_out(hwe_out),
      .load_misaligned(mis), .debug_reg_write_en(dbg_en), .debug_pc_addr_out(dbg_pc)
   );

   wb_load_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) dut64 (
      .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .flush(1'b0),
      .mem_read_flag(w_read), .mem_write_flag(1'b0), .mem_sign_flag(w_sign),
      .mem_size(w_size), .result_in(w_result_in), .reg_write_en_in(1'b1),
      .reg_write_addr_in(5'd20), .current_pc_addr_in(32'h800), .hi_write_data_in(64'h0),
      .lo_write_data_in(64'h0), .hilo_write_en_in(1'b0), .ram_rvalid(w_rvalid),
      .ram_read_data(w_rdata), .wb_valid(w_wb_valid), .result_out(w_result_out),
      .reg_write_en_out(w_rwe_out), .reg_write_addr_out(w_raddr_out),
      .hi_write_data_out(w_hi_out), .lo_write_data_out(w_lo_out),
      .hilo_write_en_out(w_hwe_out), .load_misaligned(w_mis),
      .debug_reg_write_en(w_dbg_en), .debug_pc_addr_out(w_dbg_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ld, st, sgn;
      logic [1:0]  sz;
      logic [31:0] res;
      logic        rwe;
      logic [4:0]  ra;
      logic [31:0] hi, lo;
      logic        hwe;
      logic [31:0] rdata;
      int          dly;
      logic        wait_rd;
      logic [31:0] e_res;
      logic        e_rwe, e_mis, e_hwe;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      in_valid = 0; flush = 0; mem_read_flag = 0; mem_write_flag = 0; mem_sign_flag = 0;
      mem_size = 0; result_in = 0; rwe_in = 0; raddr_in = 0; pc_in = 0;
      hi_in = 0; lo_in = 0; hwe_in = 0; ram_rvalid = 0; ram_read_data = 0;
      w_in_valid = 0; w_read = 0; w_sign = 0; w_size = 0; w_result_in = 0;
      w_rvalid = 0; w_rdata = 0;
   endtask

   task automatic present(input logic ld, input logic st, input logic sgn, input logic [1:0] sz,
                          input logic [31:0] res, input logic rwe, input logic [4:0] ra);
      in_valid = 1; mem_read_flag = ld; mem_write_flag = st; mem_sign_flag = sgn;
      mem_size = sz; result_in = res; rwe_in = rwe; raddr_in = ra;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      present(v.ld, v.st, v.sgn, v.sz, v.res, v.rwe, v.ra);
      hi_in = v.hi; lo_in = v.lo; hwe_in = v.hwe; pc_in = 32'h400 + 32'(idx * 4);
      tick();
      clear_in();
      if (v.wait_rd) begin
         chk($sformatf("v%0d_wait_no_beat", idx), 64'(wb_valid), 64'(0));
         chk($sformatf("v%0d_wait_busy", idx), 64'(in_ready), 64'(0));
         repeat (v.dly) tick();
         ram_rvalid = 1; ram_read_data = v.rdata;
         tick();
         ram_rvalid = 0; ram_read_data = 0;
      end
      chk($sformatf("v%0d_wb_valid", idx), 64'(wb_valid), 64'(1));
      chk($sformatf("v%0d_result", idx), 64'(result_out), 64'(v.e_res));
      chk($sformatf("v%0d_rwe", idx), 64'(rwe_out), 64'(v.e_rwe));
      chk($sformatf("v%0d_dbg_en", idx), 64'(dbg_en), 64'(v.e_rwe));
      chk($sformatf("v%0d_raddr", idx), 64'(raddr_out), 64'(v.ra));
      chk($sformatf("v%0d_misaligned", idx), 64'(mis), 64'(v.e_mis));
      chk($sformatf("v%0d_hwe", idx), 64'(hwe_out), 64'(v.e_hwe));
      chk($sformatf("v%0d_pc", idx), 64'(dbg_pc), 64'(32'h400 + 32'(idx * 4)));
      chk($sformatf("v%0d_ready", idx), 64'(in_ready), 64'(1));
      if (!v.ld) begin
         chk($sformatf("v%0d_hi", idx), 64'(hi_out), 64'(v.hi));
         chk($sformatf("v%0d_lo", idx), 64'(lo_out), 64'(v.lo));
      end
   endtask

   task automatic run64(input string name, input logic sgn, input logic [1:0] sz,
                        input logic [63:0] addr, input logic [63:0] data,
                        input logic exp_mis, input logic [63:0] exp);
      w_in_valid = 1; w_read = 1; w_sign = sgn; w_size = sz; w_result_in = addr;
      tick();
      w_in_valid = 0; w_read = 0;
      if (!exp_mis) begin
         chk({name, "_no_beat"}, 64'(w_wb_valid), 64'(0));
         tick();
         w_rvalid = 1; w_rdata = data;
         tick();
         w_rvalid = 0;
      end
      chk({name, "_wb_valid"}, 64'(w_wb_valid), 64'(1));
      chk({name, "_mis"}, 64'(w_mis), 64'(exp_mis));
      chk({name, "_result"}, w_result_out, exp);
      chk({name, "_rwe"}, 64'(w_rwe_out), 64'(!exp_mis));
   endtask

   initial begin
      //          ld st sg sz res            rwe ra  hi      lo      hwe rdata          dly wt e_res          erwe emis ehwe
      vecs[0]  = '{0, 0, 0, 0, 32'h12345678, 1, 7,  0,      0,      0, 0,             0, 0, 32'h12345678, 1, 0, 0};
      vecs[1]  = '{1, 0, 1, 0, 32'h00001003, 1, 3,  0,      0,      0, 32'h80FF0000,  3, 1, 32'hFFFFFF80, 1, 0, 0};
      vecs[2]  = '{1, 0, 0, 0, 32'h00001003, 1, 4,  0,      0,      0, 32'h80FF0000,  3, 1, 32'h00000080, 1, 0, 0};
      vecs[3]  = '{1, 0, 1, 1, 32'h00002001, 1, 5,  0,      0,      0, 0,             0, 0, 32'h0,        0, 1, 0};
      vecs[4]  = '{0, 1, 0, 2, 32'h0000DEAD, 1, 6,  0,      0,      0, 0,             0, 0, 32'h0,        0, 0, 0};
      vecs[5]  = '{1, 0, 1, 1, 32'h00003002, 1, 8,  0,      0,      0, 32'h80017FFF,  0, 1, 32'hFFFF8001, 1, 0, 0};
      vecs[6]  = '{1, 0, 0, 1, 32'h00003000, 1, 9,  0,      0,      0, 32'h80017FFF,  1, 1, 32'h00007FFF, 1, 0, 0};
      vecs[7]  = '{1, 0, 1, 2, 32'h00004000, 1, 10, 0,      0,      0, 32'hCAFEBABE,  2, 1, 32'hCAFEBABE, 1, 0, 0};
      vecs[8]  = '{1, 0, 1, 3, 32'h00005000, 1, 11, 0,      0,      0, 0,             0, 0, 32'h0,        0, 1, 0};
      vecs[9]  = '{0, 0, 0, 0, 32'h00000000, 0, 0,  32'h11, 32'h22,  1, 0,             0, 0, 32'h0,        0, 0, 1};
      vecs[10] = '{1, 0, 0, 2, 32'h00006002, 1, 12, 0,      0,      0, 0,             0, 0, 32'h0,        0, 1, 0};
      vecs[11] = '{1, 0, 1, 0, 32'h00007001, 1, 13, 0,      0,      0, 32'h00007F00,  0, 1, 32'h0000007F, 1, 0, 0};
      vecs[12] = '{1, 0, 1, 0, 32'h00007002, 0, 14, 0,      0,      0, 32'h00AB0000,  1, 1, 32'hFFFFFFAB, 0, 0, 0};

      rst = 1;
      clear_in();
      #1 rst = 0;
      #10;
      chk("reset_wb_valid", 64'(wb_valid), 64'(0));
      chk("reset_result", 64'(result_out), 64'(0));
      chk("reset_rwe", 64'(rwe_out), 64'(0));
      chk("reset_mis", 64'(mis), 64'(0));
      chk("reset_pc", 64'(dbg_pc), 64'(0));
      chk("reset_ready", 64'(in_ready), 64'(1));
      chk("reset_ready64", 64'(w_in_ready), 64'(1));
      rst = 1;
      tick();

      for (int i = 0; i < 13; i++) run_vec(vecs[i], i);
      tick();
      chk("idle_no_beat", 64'(wb_valid), 64'(0));
      chk("idle_no_rwe", 64'(rwe_out), 64'(0));
      chk("idle_no_hwe", 64'(hwe_out), 64'(0));

      // misaligned load followed back-to-back by two ALU ops
      present(1, 0, 1, 1, 32'h00000001, 1, 2);
      tick();
      chk("b2b_mis", 64'(mis), 64'(1));
      chk("b2b_ready", 64'(in_ready), 64'(1));
      present(0, 0, 0, 2, 32'h000000A5, 1, 3);
      tick();
      chk("b2b_alu1_valid", 64'(wb_valid), 64'(1));
      chk("b2b_alu1_mis", 64'(mis), 64'(0));
      chk("b2b_alu1_result", 64'(result_out), 64'(32'hA5));
      present(0, 0, 0, 2, 32'h0000005A, 1, 4);
      tick();
      chk("b2b_alu2_result", 64'(result_out), 64'(32'h5A));
      chk("b2b_alu2_raddr", 64'(raddr_out), 64'(4));
      clear_in();
      tick();
      chk("b2b_drop_valid", 64'(wb_valid), 64'(0));

      // flush while idle: input ignored
      present(0, 0, 0, 2, 32'h00000077, 1, 9);
      flush = 1;
      tick();
      clear_in();
      chk("flush_idle_no_beat", 64'(wb_valid), 64'(0));
      chk("flush_idle_no_rwe", 64'(rwe_out), 64'(0));

      // flush in WAIT_RD, response two cycles later is drained
      present(1, 0, 0, 2, 32'h00000100, 1, 6);
      tick();
      clear_in();
      flush = 1;
      tick();
      flush = 0;
      chk("drain_busy", 64'(in_ready), 64'(0));
      tick();
      chk("drain_still_busy", 64'(in_ready), 64'(0));
      ram_rvalid = 1; ram_read_data = 32'h55555555;
      tick();
      ram_rvalid = 0;
      chk("drain_no_beat", 64'(wb_valid), 64'(0));
      chk("drain_ready", 64'(in_ready), 64'(1));
      tick();
      chk("drain_no_late_beat", 64'(wb_valid), 64'(0));

      // flush together with the response
      present(1, 0, 0, 2, 32'h00000104, 1, 6);
      tick();
      clear_in();
      flush = 1; ram_rvalid = 1; ram_read_data = 32'h66666666;
      tick();
      clear_in();
      chk("flushrv_no_beat", 64'(wb_valid), 64'(0));
      chk("flushrv_ready", 64'(in_ready), 64'(1));

      // reset in WAIT_RD, then a stray response
      present(0, 0, 0, 2, 32'h0000BEEF, 1, 1);
      tick();
      present(1, 0, 1, 2, 32'h00000200, 1, 17);
      tick();
      clear_in();
      #2 rst = 0;
      #1;
      chk("rst_mid_valid", 64'(wb_valid), 64'(0));
      chk("rst_mid_result", 64'(result_out), 64'(0));
      chk("rst_mid_raddr", 64'(raddr_out), 64'(0));
      chk("rst_mid_ready", 64'(in_ready), 64'(1));
      #1 rst = 1;
      tick();
      ram_rvalid = 1; ram_read_data = 32'h12121212;
      tick();
      ram_rvalid = 0;
      chk("rst_stray_no_beat", 64'(wb_valid), 64'(0));
      chk("rst_stray_ready", 64'(in_ready), 64'(1));

      // 64-bit datapath
      run64("ld_off0", 1, 2'd3, 64'h1000, 64'h0123456789ABCDEF, 0, 64'h0123456789ABCDEF);
      run64("lw_off4", 1, 2'd2, 64'h1004, 64'h0123456789ABCDEF, 0, 64'h0000000001234567);
      run64("lh_off6", 1, 2'd1, 64'h1006, 64'h8001000000000000, 0, 64'hFFFFFFFFFFFF8001);
      run64("ld_off4", 1, 2'd3, 64'h1004, 64'h0, 1, 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
